// File: rtl/mem_lane_ctrl.sv
// Memory-access lane controller between the MEM stage and the data-memory bus.
// Builds byte enables and lane-steered store data for any power-of-two bus
// width, extracts and extends load data, and splits lane-crossing misaligned
// accesses into two bus beats. One request in flight; the stage stalls on
// req_ready.
//
// state | meaning
// IDLE  | ready for a new request
// BEAT0 | first (or only) bus beat outstanding
// BEAT1 | second beat of a lane-crossing access outstanding
// RESP  | one-cycle completion pulse on rsp_valid
module mem_lane_ctrl #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic                req_sext,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                bus_valid,
    input  logic                bus_ready,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic [DATA_W-1:0]   bus_rdata,
    output logic                rsp_valid,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   rsp_rdata
);
    localparam int NB = DATA_W / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

    state_t state, state_nxt;

    logic              we_q, sext_q, cross_q;
    logic [1:0]        size_q;
    logic [OB-1:0]     off_q;
    logic [NB-1:0]     be_hi_q;
    logic [DATA_W-1:0] wdata_hi_q;
    logic [DATA_W-1:0] rdata_lo_q;

    logic              accept, req_err, req_misal, req_cross;
    logic [OB-1:0]     req_off;
    logic [3:0]        req_sz, off_ext, sz_q;
    logic [2*NB-1:0]   be_base, be_wide;
    logic [2*DATA_W-1:0] wd_wide, rd_cat;
    logic [DATA_W-1:0] rd_shift, rd_ext;
    logic              rd_sign;

    // Request decode: size, offset, misalignment, crossing, error and beat masks
    always_comb begin
        req_off   = req_addr[OB-1:0];
        off_ext   = 4'(req_off);
        req_sz    = 4'd1 << req_size;
        req_misal = (off_ext & (req_sz - 4'd1)) != 4'd0;
        req_cross = ({1'b0, off_ext} + {1'b0, req_sz}) > 5'(NB);
        req_err   = ((req_size == 2'd3) && (NB < 8)) ||
                    (req_misal && (ALLOW_MISALIGN == 0));
        accept    = req_valid && req_ready;
        be_base   = '0;
        for (int i = 0; i < 2 * NB; i++) begin
            be_base[i] = (i < int'(req_sz));
        end
        // Low half of each wide vector is beat 0, high half is beat 1.
        be_wide = be_base << req_off;
        wd_wide = {{DATA_W{1'b0}}, req_wdata} << {req_off, 3'b000};
    end

    // Load extraction: the two beats concatenated act as one wide window
    always_comb begin
        sz_q   = 4'd1 << size_q;
        rd_cat = (state == BEAT1) ? {bus_rdata, rdata_lo_q}
                                  : {{DATA_W{1'b0}}, bus_rdata};
        rd_shift = DATA_W'(rd_cat >> {off_q, 3'b000});
        case (size_q)
            2'd0:    rd_sign = rd_shift[7];
            2'd1:    rd_sign = rd_shift[15];
            2'd2:    rd_sign = rd_shift[31];
            default: rd_sign = rd_shift[DATA_W-1];
        endcase
        rd_ext = '0;
        for (int j = 0; j < NB; j++) begin
            rd_ext[8*j +: 8] = (j < int'(sz_q)) ? rd_shift[8*j +: 8]
                                                : {8{sext_q & rd_sign}};
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        bus_valid = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = reset;
                if (accept) state_nxt = req_err ? RESP : BEAT0;
            end
            BEAT0: begin
                bus_valid = 1'b1;
                if (bus_ready) state_nxt = cross_q ? BEAT1 : RESP;
            end
            BEAT1: begin
                bus_valid = 1'b1;
                if (bus_ready) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, beat field sequencing and registered response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            cross_q    <= 1'b0;
            size_q     <= 2'd0;
            off_q      <= '0;
            be_hi_q    <= '0;
            wdata_hi_q <= '0;
            rdata_lo_q <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q       <= req_we;
                    sext_q     <= req_sext;
                    cross_q    <= req_cross;
                    size_q     <= req_size;
                    off_q      <= req_off;
                    bus_we     <= req_we;
                    bus_addr   <= {req_addr[ADDR_W-1:OB], {OB{1'b0}}};
                    bus_be     <= be_wide[NB-1:0];
                    be_hi_q    <= be_wide[2*NB-1:NB];
                    bus_wdata  <= wd_wide[DATA_W-1:0];
                    wdata_hi_q <= wd_wide[2*DATA_W-1:DATA_W];
                    rsp_err    <= req_err;
                    rsp_rdata  <= '0;
                end
                BEAT0: if (bus_ready) begin
                    rdata_lo_q <= bus_rdata;
                    if (cross_q) begin
                        bus_addr  <= bus_addr + ADDR_W'(NB);
                        bus_be    <= be_hi_q;
                        bus_wdata <= wdata_hi_q;
                    end else begin
                        rsp_rdata <= we_q ? '0 : rd_ext;
                    end
                end
                BEAT1: if (bus_ready) begin
                    rsp_rdata <= we_q ? '0 : rd_ext;
                end
                RESP: begin
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_lane_ctrl.sv
// Bench for mem_lane_ctrl: three instances (32-bit misalign allowed,
// 32-bit misalign disallowed, 64-bit) driven from one vector table.
module tb_mem_lane_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_we, req_sext, bus_ready;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, bus_rdata;
    int          sel;
    int          cyc = 0;
    int          n_cmp = 0, n_fail = 0;

    logic        a_rr, a_bv, a_bwe, a_rv, a_re;
    logic [31:0] a_ba, a_bw, a_rd;
    logic [3:0]  a_be;
    logic        b_rr, b_bv, b_bwe, b_rv, b_re;
    logic [31:0] b_ba, b_bw, b_rd;
    logic [3:0]  b_be;
    logic        c_rr, c_bv, c_bwe, c_rv, c_re;
    logic [31:0] c_ba;
    logic [63:0] c_bw, c_rd;
    logic [7:0]  c_be;

    mem_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(1)) u_a (
        .clk(clk), .reset(rst_n), .req_valid(req_valid && sel == 0), .req_ready(a_rr),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .bus_valid(a_bv), .bus_ready(bus_ready), .bus_we(a_bwe),
        .bus_addr(a_ba), .bus_be(a_be), .bus_wdata(a_bw), .bus_rdata(bus_rdata[31:0]),
        .rsp_valid(a_rv), .rsp_err(a_re), .rsp_rdata(a_rd));
    mem_lane_ctrl #(.DATA_W(32), .ADDR_W(32), .ALLOW_MISALIGN(0)) u_b (
        .clk(clk), .reset(rst_n), .req_valid(req_valid && sel == 1), .req_ready(b_rr),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .bus_valid(b_bv), .bus_ready(bus_ready), .bus_we(b_bwe),
        .bus_addr(b_ba), .bus_be(b_be), .bus_wdata(b_bw), .bus_rdata(bus_rdata[31:0]),
        .rsp_valid(b_rv), .rsp_err(b_re), .rsp_rdata(b_rd));
    mem_lane_ctrl #(.DATA_W(64), .ADDR_W(32), .ALLOW_MISALIGN(1)) u_c (
        .clk(clk), .reset(rst_n), .req_valid(req_valid && sel == 2), .req_ready(c_rr),
        .req_we(req_we), .req_size(req_size), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .bus_valid(c_bv), .bus_ready(bus_ready), .bus_we(c_bwe),
        .bus_addr(c_ba), .bus_be(c_be), .bus_wdata(c_bw), .bus_rdata(bus_rdata),
        .rsp_valid(c_rv), .rsp_err(c_re), .rsp_rdata(c_rd));

    // Selected instance's outputs, widened to 64-bit data
    logic        m_rr, m_bv, m_bwe, m_rv, m_re;
    logic [31:0] m_ba;
    logic [7:0]  m_be;
    logic [63:0] m_bw, m_rd;
    always_comb begin
        m_rr = c_rr; m_bv = c_bv; m_bwe = c_bwe; m_rv = c_rv; m_re = c_re;
        m_ba = c_ba; m_be = c_be; m_bw = c_bw; m_rd = c_rd;
        if (sel == 0) begin
            m_rr = a_rr; m_bv = a_bv; m_bwe = a_bwe; m_rv = a_rv; m_re = a_re;
            m_ba = a_ba; m_be = {4'h0, a_be}; m_bw = {32'h0, a_bw}; m_rd = {32'h0, a_rd};
        end else if (sel == 1) begin
            m_rr = b_rr; m_bv = b_bv; m_bwe = b_bwe; m_rv = b_rv; m_re = b_re;
            m_ba = b_ba; m_be = {4'h0, b_be}; m_bw = {32'h0, b_bw}; m_rd = {32'h0, b_rd};
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          dut;
        logic        we;
        logic [1:0]  size;
        logic        sext;
        logic [31:0] addr;
        logic [63:0] wdata;
        int          nb;
        int          stall;
        logic [31:0] a0, a1;
        logic [7:0]  be0, be1;
        logic [63:0] wd0, wd1, rd0, rd1;
        logic        err;
        logic [63:0] rdata;
    } vec_t;

    typedef struct {
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[17];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(int dut, logic we, logic [1:0] size, logic sext,
                                logic [31:0] addr, logic [63:0] wdata, int nb, int stall,
                                logic [31:0] a0, logic [7:0] be0, logic [63:0] wd0, logic [63:0] rd0,
                                logic [31:0] a1, logic [7:0] be1, logic [63:0] wd1, logic [63:0] rd1,
                                logic err, logic [63:0] rdata);
        vec_t v;
        v.dut = dut; v.we = we; v.size = size; v.sext = sext; v.addr = addr; v.wdata = wdata;
        v.nb = nb; v.stall = stall; v.a0 = a0; v.be0 = be0; v.wd0 = wd0; v.rd0 = rd0;
        v.a1 = a1; v.be1 = be1; v.wd1 = wd1; v.rd1 = rd1; v.err = err; v.rdata = rdata;
        return v;
    endfunction

    // Scoreboard: every completion pulse is matched against the oldest expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && m_rv === 1'b1) begin
            if (sb.size() == 0) begin
                chk("rsp_unexpected", 64'(m_rv), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_cycle", 64'(cyc), 64'(e.cyc));
                chk("rsp_err", 64'(m_re), 64'(e.err));
                chk("rsp_rdata", m_rd, e.rdata);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        sel = v.dut;
        @(negedge clk);
        chk("req_ready_idle", 64'(m_rr), 64'd1);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_sext = v.sext;
        req_addr = v.addr; req_wdata = v.wdata;
        e.err = v.err; e.rdata = v.rdata;
        e.cyc = cyc + (v.err ? 1 : 1 + v.nb * (v.stall + 1));
        sb.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
        for (int b = 0; b < v.nb; b++) begin
            for (int s = 0; s <= v.stall; s++) begin
                if (b != 0 || s != 0) @(negedge clk);
                chk("bus_valid", 64'(m_bv), 64'd1);
                chk("bus_we", 64'(m_bwe), 64'(v.we));
                chk("bus_addr", 64'(m_ba), 64'(b == 0 ? v.a0 : v.a1));
                chk("bus_be", 64'(m_be), 64'(b == 0 ? v.be0 : v.be1));
                chk("bus_wdata", m_bw, b == 0 ? v.wd0 : v.wd1);
                bus_ready = (s == v.stall);
                bus_rdata = (b == 0) ? v.rd0 : v.rd1;
            end
        end
        if (v.nb > 0) @(negedge clk);
        bus_ready = 1'b0;
        chk("bus_valid_resp", 64'(m_bv), 64'd0);
        @(negedge clk);
        chk("req_ready_after", 64'(m_rr), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_sext = 1'b0; req_size = 2'd0;
        req_addr = '0; req_wdata = '0; bus_ready = 1'b0; bus_rdata = '0; sel = 0;

        //          dut we sz sx addr          wdata                  nb st a0            be0    wd0                    rd0                    a1            be1    wd1                    rd1                    err   rdata
        vecs[0]  = mk(0, 1, 2, 0, 32'h1000,     64'hAABBCCDD,           1, 0, 32'h1000,     8'hF,  64'hAABBCCDD,           64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h0);
        vecs[1]  = mk(0, 1, 0, 0, 32'h1003,     64'h000000EE,           1, 0, 32'h1000,     8'h8,  64'hEE000000,           64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h0);
        vecs[2]  = mk(0, 1, 1, 0, 32'h1002,     64'h00001234,           1, 0, 32'h1000,     8'hC,  64'h12340000,           64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h0);
        vecs[3]  = mk(0, 0, 2, 1, 32'h1003,     64'h0,                  2, 0, 32'h1000,     8'h8,  64'h0,                  64'h80AABBCC,          32'h1004,     8'h7,  64'h0,                 64'hDD332211,          1'b0, 64'h33221180);
        vecs[4]  = mk(0, 0, 2, 1, 32'h1003,     64'h0,                  2, 2, 32'h1000,     8'h8,  64'h0,                  64'h80AABBCC,          32'h1004,     8'h7,  64'h0,                 64'hDD332211,          1'b0, 64'h33221180);
        vecs[5]  = mk(0, 0, 0, 1, 32'h2001,     64'h0,                  1, 0, 32'h2000,     8'h2,  64'h0,                  64'h0000F500,          32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'hFFFFFFF5);
        vecs[6]  = mk(0, 0, 0, 0, 32'h2001,     64'h0,                  1, 0, 32'h2000,     8'h2,  64'h0,                  64'h0000F500,          32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h000000F5);
        vecs[7]  = mk(1, 0, 1, 0, 32'h1001,     64'h0,                  0, 0, 32'h0,        8'h0,  64'h0,                  64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b1, 64'h0);
        vecs[8]  = mk(0, 1, 3, 0, 32'h1000,     64'h12345678,           0, 0, 32'h0,        8'h0,  64'h0,                  64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b1, 64'h0);
        vecs[9]  = mk(2, 1, 3, 0, 32'h8,        64'h1122334455667788,   1, 0, 32'h8,        8'hFF, 64'h1122334455667788,   64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h0);
        vecs[10] = mk(2, 0, 3, 1, 32'h8,        64'h0,                  1, 1, 32'h8,        8'hFF, 64'h0,                  64'h8877665544332211,  32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h8877665544332211);
        vecs[11] = mk(0, 0, 1, 1, 32'h1001,     64'h0,                  1, 0, 32'h1000,     8'h6,  64'h0,                  64'h00ABCD00,          32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'hFFFFABCD);
        vecs[12] = mk(0, 1, 1, 0, 32'h1003,     64'h00005566,           2, 1, 32'h1000,     8'h8,  64'h66000000,           64'h0,                 32'h1004,     8'h1,  64'h00000055,          64'h0,                 1'b0, 64'h0);
        vecs[13] = mk(0, 0, 2, 0, 32'hFFFFFFFE, 64'h0,                  2, 0, 32'hFFFFFFFC, 8'hC,  64'h0,                  64'hBBAA0000,          32'h0,        8'h3,  64'h0,                 64'h0000DDCC,          1'b0, 64'hDDCCBBAA);
        vecs[14] = mk(2, 0, 0, 1, 32'h15,       64'h0,                  1, 0, 32'h10,       8'h20, 64'h0,                  64'h00007F0000000000,  32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h7F);
        vecs[15] = mk(2, 0, 2, 1, 32'h1E,       64'h0,                  2, 0, 32'h18,       8'hC0, 64'h0,                  64'h2211000000000000,  32'h20,       8'h03, 64'h0,                 64'h8433,              1'b0, 64'hFFFFFFFF84332211);
        vecs[16] = mk(1, 1, 2, 0, 32'h100,      64'hCAFEF00D,           1, 0, 32'h100,      8'hF,  64'hCAFEF00D,           64'h0,                 32'h0,        8'h0,  64'h0,                 64'h0,                 1'b0, 64'h0);

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(m_rr), 64'd0);
        chk("reset_bus_valid", 64'(m_bv), 64'd0);
        chk("reset_rsp_valid", 64'(m_rv), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_reset_req_ready", 64'(m_rr), 64'd1);
        chk("post_reset_bus_we", 64'(m_bwe), 64'd0);
        chk("post_reset_bus_addr", 64'(m_ba), 64'd0);
        chk("post_reset_bus_be", 64'(m_be), 64'd0);
        chk("post_reset_bus_wdata", m_bw, 64'd0);
        chk("post_reset_rsp_err", 64'(m_re), 64'd0);
        chk("post_reset_rsp_rdata", m_rd, 64'd0);

        for (int i = 0; i < 17; i++) run_vec(vecs[i]);

        // Reset while a beat is stalled: access dropped, no response
        sel = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_sext = 1'b0;
        req_addr = 32'h3000; req_wdata = '0; bus_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        chk("stall_bus_valid", 64'(m_bv), 64'd1);
        chk("stall_bus_addr", 64'(m_ba), 64'h3000);
        @(negedge clk);
        chk("stall_bus_valid_held", 64'(m_bv), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_bus_valid", 64'(m_bv), 64'd0);
        chk("midreset_req_ready", 64'(m_rr), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("midreset_rsp_valid", 64'(m_rv), 64'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("release_req_ready", 64'(m_rr), 64'd1);
        @(negedge clk);
        chk("release_rsp_valid", 64'(m_rv), 64'd0);
        run_vec(vecs[0]);
        run_vec(vecs[3]);

        repeat (3) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run still active at %0t, required completion", $time);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_lane_ctrl.md
# mem_lane_ctrl

Parametrised memory-access lane controller sitting between the MEM stage and the data-memory bus. Generalises byte-enable generation to any power-of-two bus width. Adds write-data lane steering, read-data extraction with sign/zero extension, and optional splitting of misaligned accesses into two bus beats under a valid/ready handshake. One request is in flight at a time; the stage stalls on `req_ready`.

## Interface
Parameters:
- `DATA_W`, 32 — bus width in bits; 32 or 64. NB = DATA_W/8 byte lanes, OB = log2(NB).
- `ADDR_W`, 32 — byte-address width.
- `ALLOW_MISALIGN`, 1 — 1: misaligned accesses are executed (split if needed); 0: flagged as error, no bus traffic.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low; all state cleared while low.
- `req_valid`  in  1  — access request.
- `req_ready`  out  1  — high only in IDLE.
- `req_we`  in  1  — 1 store, 0 load.
- `req_size`  in  2  — 0 byte, 1 half, 2 word, 3 dword (legal only when DATA_W=64).
- `req_sext`  in  1  — loads: sign-extend when 1, else zero-extend.
- `req_addr`  in  ADDR_W  — byte address.
- `req_wdata`  in  DATA_W  — store data, right-justified.
- `bus_valid`  out  1  — beat request.
- `bus_ready`  in  1  — beat accepted; for loads `bus_rdata` is valid in the same cycle.
- `bus_we`  out  1  — copy of latched `req_we`.
- `bus_addr`  out  ADDR_W  — NB-aligned beat address.
- `bus_be`  out  NB  — byte enables, bit i = lane i, little-endian.
- `bus_wdata`  out  DATA_W  — lane-steered store data.
- `bus_rdata`  in  DATA_W  — load data.
- `rsp_valid`  out  1  — one-cycle completion pulse; consumer cannot back-pressure.
- `rsp_err`  out  1  — valid with `rsp_valid`: illegal size or disallowed misalignment.
- `rsp_rdata`  out  DATA_W  — extracted, extended load data; 0 for stores and errors.

## Operation
- Request latched on `req_valid & req_ready`. Definitions: SZ = 1<<size bytes; OFF = addr[OB-1:0]; BASE = addr with low OB bits cleared.
- Misaligned: OFF mod SZ != 0. Crossing: OFF+SZ > NB.
- Error: size 3 with DATA_W=32, or misaligned with ALLOW_MISALIGN=0. Goes to RESP with `rsp_err`=1 and issues no beat.
- Beat 0: `bus_addr`=BASE; `bus_be`=((1<<SZ)-1)<<OFF, truncated to NB bits; `bus_wdata`=wdata<<(8*OFF).
- Beat 1 (crossing only): `bus_addr`=BASE+NB, wrapping modulo 2^ADDR_W; `bus_be`=((1<<SZ)-1)>>(NB-OFF); `bus_wdata`=wdata>>(8*(NB-OFF)).
- Loads: byte j of the result is taken from the beat-0 lane OFF+j, or from the beat-1 lane OFF+j-NB. Bits above 8*SZ are filled with the top result bit when `req_sext`=1, else with 0.
- FSM states and transitions:
  - IDLE → accept → BEAT0, or RESP on error.
  - BEAT0 → on `bus_ready`: BEAT1 if crossing, else RESP.
  - BEAT1 → on `bus_ready`: RESP.
  - RESP → IDLE unconditionally.
- `bus_valid`=1 exactly in BEAT0/BEAT1. `bus_addr`, `bus_be`, `bus_wdata` and `bus_we` are held stable while `bus_valid & !bus_ready`.
- Reset mid-operation: the FSM returns to IDLE and the in-flight access is dropped with no `rsp_valid`.
- Reset values: `req_ready`=1 after reset deasserts (0 while `reset` low). `bus_valid`, `rsp_valid`, `rsp_err`, `bus_we`=0. `bus_addr`, `bus_be`, `bus_wdata`, `rsp_rdata`=0.

## Timing
- Accept at cycle T; `bus_valid` rises at T+1.
- Each beat lasts ≥1 cycle and completes in the cycle where `bus_ready`=1.
- `rsp_valid` is high the cycle after the final beat completes. Zero-wait, single-beat access: `rsp_valid` at T+2. Crossing access: T+3.
- Error: `rsp_valid` at T+1.
- `req_ready` returns high the cycle after `rsp_valid`; the earliest next accept is T+3 for a single zero-wait beat.
- `rsp_rdata` and `rsp_err` are registered and valid only while `rsp_valid`=1.

## Test plan
- DATA_W=32, store word at 0x1000, wdata 0xAABBCCDD, `bus_ready` tied 1 → one beat: addr 0x1000, be 1111, wdata 0xAABBCCDD; `rsp_valid` at T+2.
- DATA_W=32, store byte at 0x1003, wdata 0x000000EE → be 1000, wdata 0xEE000000. Half at 0x1002 → be 1100.
- DATA_W=32, ALLOW_MISALIGN=1, load word at 0x1003 with sext. Beat 0: addr 0x1000, be 1000, rdata 0x80xxxxxx. Beat 1: addr 0x1004, be 0111, rdata 0xxx332211 → `rsp_rdata`=0x33221180. Rerun with `bus_ready` low for 2 cycles per beat; outputs stable, `rsp_valid` at T+7.
- DATA_W=32, load byte at 0x2001, rdata 0x0000F500: sext → 0xFFFFFFF5; zext → 0x000000F5.
- ALLOW_MISALIGN=0, half at 0x1001 → no `bus_valid`; `rsp_valid`=1 and `rsp_err`=1 at T+1. DATA_W=32 with size 3 → same response. DATA_W=64, dword at 0x8 → be 0xFF, single beat.
- Assert `reset` low while in BEAT0 stalled → `bus_valid` drops immediately, no `rsp_valid`; after release `req_ready`=1 and a new access completes normally.
